// File: rtl/simple_proc_pkg.sv
// Shared types and constants for the simple_microprocessor front end.
package simple_proc_pkg;

  // Per-button debounce FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    PRESSED   = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  // Basys3 push-button bit positions within btn_raw
  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

endpackage

// File: rtl/button_debounce_one.sv
// One button channel: 2-FF synchronizer, debounce FSM with stability
// counter, and registered level / press / release outputs.
module button_debounce_one
  import simple_proc_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;
  logic             press_nxt;
  logic             rel_nxt;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // State, stability counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      press <= press_nxt;
      rel   <= rel_nxt;
    end
  end

  // Next state: a change is accepted only after DB_CYCLES stable samples
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (sync_p1) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync_p1)             state_nxt = IDLE;
        else if (cnt == CNT_LAST) state_nxt = PRESSED;
        else                      cnt_nxt   = cnt + CNT_W'(1);
      end
      PRESSED: begin
        if (!sync_p1) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync_p1)              state_nxt = PRESSED;
        else if (cnt == CNT_LAST) state_nxt = IDLE;
        else                      cnt_nxt   = cnt + CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the transition being taken, so they register with it
  always_comb begin
    level_nxt = (state_nxt == PRESSED) || (state_nxt == WAIT_LOW);
    press_nxt = (state == WAIT_HIGH) && (state_nxt == PRESSED);
    rel_nxt   = (state == WAIT_LOW) && (state_nxt == IDLE);
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the five Basys3 push buttons: N_BTN independent debounce
// channels, each giving a clean level and one-cycle press/release pulses.
module button_conditioner
  import simple_proc_pkg::*;
#(
  parameter int N_BTN     = 5,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic             CLK100MHZ,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int CNT_W = $clog2(DB_CYCLES);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    button_debounce_one #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_db (
      .clk   (CLK100MHZ),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .level (btn_level[i]),
      .press (btn_press[i]),
      .rel   (btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DB_CYCLES=4: each scenario queues the
// expected {level, press, release} trace per edge, then drives stimulus and
// pops one expectation after every rising edge.
module tb_button_conditioner;
  import simple_proc_pkg::*;

  localparam int N   = 5;
  localparam int DB  = 4;
  localparam int LAT = DB + 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  logic [3*N-1:0] exp_q[$];
  logic [3*N-1:0] got;
  logic [3*N-1:0] want;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_conditioner #(.N_BTN(N), .DB_CYCLES(DB)) dut (
    .CLK100MHZ   (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  function automatic logic [3*N-1:0] pack(logic [N-1:0] lvl, logic [N-1:0] prs, logic [N-1:0] rls);
    return {lvl, prs, rls};
  endfunction

  // Reset with all buttons held, then acceptance and release of all five
  task automatic test_reset();
    for (int k = 1; k <= 3; k++) exp_q.push_back(pack('0, '0, '0));
    for (int k = 1; k <= 10; k++)
      exp_q.push_back(pack(k >= LAT ? 5'b11111 : 5'b0, k == LAT ? 5'b11111 : 5'b0, 5'b0));
    for (int k = 1; k <= 10; k++)
      exp_q.push_back(pack(k < LAT ? 5'b11111 : 5'b0, 5'b0, k == LAT ? 5'b11111 : 5'b0));
    btn_raw = 5'b11111;
    rst = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      if (k == 4)  rst = 1'b0;
      if (k == 14) btn_raw = 5'b0;
      @(posedge clk); #1;
      got  = {btn_level, btn_press, btn_release};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset step %0d got %h want %h", k, got, want);
      end
    end
  endtask

  // Clean press of btnL held for 20 edges
  task automatic test_clean_press();
    for (int k = 1; k <= 20; k++)
      exp_q.push_back(pack(k >= LAT ? 5'b00100 : 5'b0, k == LAT ? 5'b00100 : 5'b0, 5'b0));
    btn_raw[BTN_L] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      got  = {btn_level, btn_press, btn_release};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL clean_press edge %0d got %h want %h", k, got, want);
      end
    end
  endtask

  // Release of btnL from the held state, single pulse only
  task automatic test_release();
    for (int k = 1; k <= 14; k++)
      exp_q.push_back(pack(k < LAT ? 5'b00100 : 5'b0, 5'b0, k == LAT ? 5'b00100 : 5'b0));
    btn_raw[BTN_L] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      got  = {btn_level, btn_press, btn_release};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL release edge %0d got %h want %h", k, got, want);
      end
    end
  endtask

  // btnC high for only DB-1 samples: must be rejected entirely
  task automatic test_bounce();
    for (int k = 1; k <= 13; k++) exp_q.push_back(pack('0, '0, '0));
    for (int k = 1; k <= 13; k++) begin
      btn_raw[BTN_C] = (k <= 3);
      @(posedge clk); #1;
      got  = {btn_level, btn_press, btn_release};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL bounce edge %0d got %h want %h", k, got, want);
      end
    end
  endtask

  // btnU and btnD rise together, pulse together, and release together
  task automatic test_simultaneous();
    for (int k = 1; k <= 10; k++)
      exp_q.push_back(pack(k >= LAT ? 5'b10010 : 5'b0, k == LAT ? 5'b10010 : 5'b0, 5'b0));
    for (int k = 1; k <= 10; k++)
      exp_q.push_back(pack(k < LAT ? 5'b10010 : 5'b0, 5'b0, k == LAT ? 5'b10010 : 5'b0));
    for (int k = 1; k <= 20; k++) begin
      btn_raw[BTN_U] = (k <= 10);
      btn_raw[BTN_D] = (k <= 10);
      @(posedge clk); #1;
      got  = {btn_level, btn_press, btn_release};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL simultaneous step %0d got %h want %h", k, got, want);
      end
    end
  endtask

  // Reset at edge 4 of a btnR debounce; acceptance restarts from edge 5
  task automatic test_reset_mid();
    for (int k = 1; k <= 14; k++)
      exp_q.push_back(pack(k >= LAT + 4 ? 5'b01000 : 5'b0, k == LAT + 4 ? 5'b01000 : 5'b0, 5'b0));
    for (int k = 1; k <= 10; k++)
      exp_q.push_back(pack(k < LAT ? 5'b01000 : 5'b0, 5'b0, k == LAT ? 5'b01000 : 5'b0));
    for (int k = 1; k <= 24; k++) begin
      rst = (k == 4);
      btn_raw[BTN_R] = (k <= 14);
      @(posedge clk); #1;
      got  = {btn_level, btn_press, btn_release};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid step %0d got %h want %h", k, got, want);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    btn_raw = '0;
    @(posedge clk); #1;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
